// File: rtl/design_32_pkg.sv
// -----------------------------------------------------------------------------
// design_32_pkg
// Shared definitions for the design_32 registered adder.
//   DESIGN_32_W_DEFAULT : default operand/result width in bits
//   sum_wrap()          : modular sum of two operands truncated to w bits,
//                         usable by checkers for any width from 1 to 64
// -----------------------------------------------------------------------------
package design_32_pkg;

    localparam int unsigned DESIGN_32_W_DEFAULT = 12;

    // Operands are carried in 64-bit containers so one function covers every
    // legal width; the carry-out beyond bit w-1 is discarded by the mask.
    function automatic logic [63:0] sum_wrap(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w
    );
        logic [63:0] s;
        s = a + b;
        if (w < 64) begin
            s = s & ((64'd1 << w) - 64'd1);
        end
        return s;
    endfunction

endpackage

// File: rtl/design_32_adder.sv
// -----------------------------------------------------------------------------
// design_32_adder
// Purely combinational W-bit modular adder built as a ripple-carry chain.
// Ports:
//   a [W-1:0] in  : first operand
//   b [W-1:0] in  : second operand
//   s [W-1:0] out : (a + b) mod 2^W, carry-out discarded
// -----------------------------------------------------------------------------
module design_32_adder
    import design_32_pkg::*;
#(
    parameter int unsigned W = DESIGN_32_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);

    // carry[gi] is the carry into bit gi; the carry out of the top bit is
    // never built because the result wraps modulo 2^W.
    logic [W-1:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign s[gi] = a[gi] ^ b[gi] ^ carry[gi];
            if (gi < W - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/design_32.sv
// -----------------------------------------------------------------------------
// design_32
// Latency-1 registered adder with a start/valid handshake, no backpressure.
// Ports:
//   clk             in  : rising-edge clock
//   rst_n           in  : asynchronous active-low reset (clears y and valid)
//   start           in  : request strobe, sampled each rising edge
//   a, b  [W-1:0]   in  : operands, sampled together with start
//   y     [W-1:0]   out : registered modular sum of the last started operands
//   valid           out : high for one cycle after each sampled start
// -----------------------------------------------------------------------------
module design_32
    import design_32_pkg::*;
#(
    parameter int unsigned W = DESIGN_32_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         valid
);

    logic [W-1:0] sum_next;
    logic [W-1:0] y_reg;
    logic         valid_reg;

    design_32_adder #(
        .W (W)
    ) u_adder (
        .a (a),
        .b (b),
        .s (sum_next)
    );

    // y only loads on start, so operands are never observed (and cannot leak
    // X) while start is low; it simply holds its previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg <= '0;
        end else if (start) begin
            y_reg <= sum_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= start;
        end
    end

    assign y     = y_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_design_32.sv
// -----------------------------------------------------------------------------
// tb_design_32
// Self-checking bench for design_32 (W = 12). A behavioural model tracks the
// expected y/valid from the start/operand history; every cycle the DUT outputs
// are compared against it with immediate assertions.
// -----------------------------------------------------------------------------
module tb_design_32;

    localparam int unsigned W = 12;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] y;
    logic         valid;

    logic [W-1:0] exp_y;
    logic         exp_valid;

    int n_assert = 0;
    int n_fail   = 0;

    design_32 #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        n_assert++;
        assert (y === exp_y) else begin
            n_fail++;
            $error("FAIL %s y observed=%0d expected=%0d", tag, y, exp_y);
        end
        n_assert++;
        assert (valid === exp_valid) else begin
            n_fail++;
            $error("FAIL %s valid observed=%0b expected=%0b", tag, valid, exp_valid);
        end
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, then check.
    task automatic cyc(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input string tag);
        start = s;
        a     = aa;
        b     = bb;
        @(posedge clk);
        if (!rst_n) begin
            exp_y     = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = s;
            if (s) begin
                exp_y = W'((32'(aa) + 32'(bb)) % (32'd1 << W));
            end
        end
        #1;
        check(tag);
        $display("cycle %s start=%0b a=%0d b=%0d -> y=%0d valid=%0b", tag, s, aa, bb, y, valid);
    endtask

    initial begin
        exp_y     = '0;
        exp_valid = 1'b0;

        // Reset held for three edges with a live request on the inputs.
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_init");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 12'd5, 12'd7, "rst_hold");
        end
        rst_n = 1'b1;
        cyc(1'b0, 12'd5, 12'd7, "rst_release0");
        cyc(1'b0, 12'd5, 12'd7, "rst_release1");

        // Single operation, then hold.
        cyc(1'b1, 12'd100, 12'd23, "single");
        cyc(1'b0, 12'd0, 12'd0, "single_hold");
        cyc(1'b0, 12'd55, 12'd66, "single_hold2");

        // Wrap-around at the 12-bit boundary.
        cyc(1'b1, 12'hFFF, 12'h002, "wrap_fff");
        cyc(1'b1, 12'h800, 12'h800, "wrap_800");
        cyc(1'b0, 12'h000, 12'h000, "wrap_idle");

        // Back-to-back starts: valid stays high, one fresh sum per cycle.
        cyc(1'b1, 12'd1, 12'd2, "b2b_0");
        cyc(1'b1, 12'd3, 12'd4, "b2b_1");
        cyc(1'b1, 12'd10, 12'd20, "b2b_2");
        cyc(1'b0, 12'd0, 12'd0, "b2b_idle");
        cyc(1'b0, 12'd0, 12'd0, "b2b_idle2");

        // Reset pulsed mid-cycle while a request is pending: request dropped.
        start = 1'b1;
        a     = 12'd9;
        b     = 12'd9;
        #2;
        rst_n     = 1'b0;
        exp_y     = '0;
        exp_valid = 1'b0;
        #1;
        check("midop_async");
        cyc(1'b1, 12'd9, 12'd9, "midop_edge");
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 12'd9, 12'd9, "midop_release");
        cyc(1'b0, 12'd0, 12'd0, "midop_release2");

        // Random transactions separated by two idle cycles with junk operands.
        for (int t = 0; t < 10; t++) begin
            cyc(1'b1, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)), "rand_op");
            cyc(1'b0, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)), "rand_idle0");
            cyc(1'b0, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)), "rand_idle1");
        end

        // A start held high across several cycles with random full-range operands.
        for (int t = 0; t < 4; t++) begin
            cyc(1'b1, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)), "rand_burst");
        end
        cyc(1'b0, 12'd0, 12'd0, "rand_burst_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
